// File: rtl/conv_window_builder.sv
`default_nettype none

// ============================================================================
//  Module      : conv_window_builder
//  Description : Builds a 3x3 sliding window per processing core from a stream
//                of 3-row column beats.  Each beat carries {top, middle,
//                bottom} rows for every core; the block keeps a two-column
//                history and emits a registered window one cycle after each
//                qualifying beat, with optional stride-2 subsampling.
//
//  Ports
//    system_clk          : clock, rising edge
//    rst                 : synchronous active-high reset
//    feature_cache_data  : PE_CORE_NUM x {top, mid, bottom} column beat
//    feature_cache_valid : one column beat this cycle (no backpressure)
//    frame_start         : latches col_size/row_size/stride, clears counters
//    col_size, row_size  : frame width / height in beats (0 is treated as 1)
//    stride              : 0 = stride 1, 1 = stride 2
//    window_data         : PE_CORE_NUM x 3x3 window, element r*3+c per core
//    window_valid        : window_data/window_col/window_row are valid
//    window_col/row      : top-left coordinate of the emitted window
//    frame_done          : single-cycle pulse aligned with the final window
//
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef FEATURE_WIDTH
`define FEATURE_WIDTH 8
`endif
`ifndef PE_CORE_NUM
`define PE_CORE_NUM 2
`endif

module conv_window_builder #(
    parameter int FEATURE_WIDTH = `FEATURE_WIDTH,
    parameter int PE_CORE_NUM   = `PE_CORE_NUM
) (
    input  logic                                   system_clk,
    input  logic                                   rst,
    input  logic [PE_CORE_NUM*3*FEATURE_WIDTH-1:0] feature_cache_data,
    input  logic                                   feature_cache_valid,
    input  logic                                   frame_start,
    input  logic [9:0]                             col_size,
    input  logic [9:0]                             row_size,
    input  logic                                   stride,
    output logic [PE_CORE_NUM*9*FEATURE_WIDTH-1:0] window_data,
    output logic                                   window_valid,
    output logic [9:0]                             window_col,
    output logic [9:0]                             window_row,
    output logic                                   frame_done
);

    localparam int C_FW    = FEATURE_WIDTH;
    localparam int C_DIN_W = PE_CORE_NUM * 3 * FEATURE_WIDTH;
    localparam int C_WIN_W = PE_CORE_NUM * 9 * FEATURE_WIDTH;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    // Control state
    logic [0:0]         r_state;
    logic [0:0]         w_next_state;
    logic [9:0]         r_col_cnt;
    logic [9:0]         r_row_cnt;
    logic [9:0]         r_col_size;
    logic [9:0]         r_row_size;
    logic               r_stride;

    // Column history (no reset needed: the col_cnt>=2 gate hides stale data)
    logic [C_DIN_W-1:0] r_left;
    logic [C_DIN_W-1:0] r_mid;

    // Registered outputs
    logic [C_WIN_W-1:0] r_window_data;
    logic               r_window_valid;
    logic [9:0]         r_window_col;
    logic [9:0]         r_window_row;
    logic               r_frame_done;

    // Per-beat decode
    logic               w_accept;
    logic [9:0]         w_cnt_col;
    logic [9:0]         w_cnt_row;
    logic [9:0]         w_col_size_eff;
    logic [9:0]         w_row_size_eff;
    logic               w_stride_eff;
    logic               w_col_last;
    logic               w_row_last;
    logic               w_win;
    logic               w_last;
    logic [9:0]         w_col_nxt;
    logic [9:0]         w_row_nxt;
    logic [C_WIN_W-1:0] w_window;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge system_clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic.  frame_start always (re)starts a frame; a
    // frame_start beat can itself be the last beat of a 1x1 frame.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (frame_start) begin
                    w_next_state = w_last ? S_IDLE : S_RUN;
                end
            end
            S_RUN: begin
                if (frame_start) begin
                    w_next_state = w_last ? S_IDLE : S_RUN;
                end else if (w_last) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Beat decode.  On a frame_start cycle the incoming configuration and
    // zeroed counters apply to a beat arriving in that same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_accept       = feature_cache_valid && ((r_state == S_RUN) || frame_start);
        w_cnt_col      = frame_start ? 10'd0 : r_col_cnt;
        w_cnt_row      = frame_start ? 10'd0 : r_row_cnt;
        w_col_size_eff = r_col_size;
        w_row_size_eff = r_row_size;
        w_stride_eff   = r_stride;
        if (frame_start) begin
            w_col_size_eff = (col_size == 10'd0) ? 10'd1 : col_size;
            w_row_size_eff = (row_size == 10'd0) ? 10'd1 : row_size;
            w_stride_eff   = stride;
        end
        w_col_last = (w_cnt_col == w_col_size_eff - 10'd1);
        w_row_last = (w_cnt_row == w_row_size_eff - 10'd1);
        // (cnt-2) is even exactly when cnt is even
        w_win      = w_accept && (w_cnt_col >= 10'd2) && (w_cnt_row >= 10'd2) &&
                     (!w_stride_eff || (!w_cnt_col[0] && !w_cnt_row[0]));
        w_last     = w_accept && w_col_last && w_row_last;
        w_col_nxt  = w_col_last ? 10'd0 : (w_cnt_col + 10'd1);
        w_row_nxt  = w_col_last ? (w_cnt_row + 10'd1) : w_cnt_row;
    end

    // ------------------------------------------------------------------
    // Window assembly: row r=0 is the top row, which sits in the MSB
    // slice of each core's input; column 2 is the beat arriving now.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < PE_CORE_NUM; i++) begin : g_core
        for (genvar r = 0; r < 3; r++) begin : g_row
            localparam int C_SRC = i*3*C_FW + (2-r)*C_FW;
            localparam int C_DST = i*9*C_FW + r*3*C_FW;
            assign w_window[C_DST          +: C_FW] = r_left[C_SRC +: C_FW];
            assign w_window[C_DST + C_FW   +: C_FW] = r_mid[C_SRC +: C_FW];
            assign w_window[C_DST + 2*C_FW +: C_FW] = feature_cache_data[C_SRC +: C_FW];
        end
    end

    // ------------------------------------------------------------------
    // Counters, configuration and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge system_clk) begin
        if (rst) begin
            r_col_cnt      <= 10'd0;
            r_row_cnt      <= 10'd0;
            r_col_size     <= 10'd1;
            r_row_size     <= 10'd1;
            r_stride       <= 1'b0;
            r_window_valid <= 1'b0;
            r_frame_done   <= 1'b0;
            r_window_col   <= 10'd0;
            r_window_row   <= 10'd0;
            r_window_data  <= '0;
        end else begin
            if (frame_start) begin
                r_col_size <= w_col_size_eff;
                r_row_size <= w_row_size_eff;
                r_stride   <= w_stride_eff;
            end
            if (w_accept) begin
                r_col_cnt <= w_col_nxt;
                r_row_cnt <= w_row_nxt;
            end else if (frame_start) begin
                r_col_cnt <= 10'd0;
                r_row_cnt <= 10'd0;
            end
            r_window_valid <= w_win;
            r_frame_done   <= w_last;
            if (w_win) begin
                r_window_col  <= w_cnt_col - 10'd2;
                r_window_row  <= w_cnt_row - 10'd2;
                r_window_data <= w_window;
            end
        end
    end

    always_ff @(posedge system_clk) begin
        if (w_accept) begin
            r_left <= r_mid;
            r_mid  <= feature_cache_data;
        end
    end

    assign window_data  = r_window_data;
    assign window_valid = r_window_valid;
    assign window_col   = r_window_col;
    assign window_row   = r_window_row;
    assign frame_done   = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_conv_window_builder.sv
`default_nettype none

// ============================================================================
//  Module      : tb_conv_window_builder
//  Description : Directed self-checking bench for conv_window_builder.
//                Core c bottom value = column index + 10*c, middle +100,
//                top +200, so a window at column x has a known layout.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_conv_window_builder;

    localparam int FW = 8;
    localparam int PE = 2;
    localparam int DW = PE*3*FW;
    localparam int WD = PE*9*FW;

    logic          system_clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] feature_cache_data = '0;
    logic          feature_cache_valid = 1'b0;
    logic          frame_start = 1'b0;
    logic [9:0]    col_size = 10'd0;
    logic [9:0]    row_size = 10'd0;
    logic          stride = 1'b0;
    logic [WD-1:0] window_data;
    logic          window_valid;
    logic [9:0]    window_col;
    logic [9:0]    window_row;
    logic          frame_done;

    conv_window_builder #(
        .FEATURE_WIDTH (FW),
        .PE_CORE_NUM   (PE)
    ) u_dut (
        .system_clk          (system_clk),
        .rst                 (rst),
        .feature_cache_data  (feature_cache_data),
        .feature_cache_valid (feature_cache_valid),
        .frame_start         (frame_start),
        .col_size            (col_size),
        .row_size            (row_size),
        .stride              (stride),
        .window_data         (window_data),
        .window_valid        (window_valid),
        .window_col          (window_col),
        .window_row          (window_row),
        .frame_done          (frame_done)
    );

    always #5 system_clk = ~system_clk;

    int pc = 0;
    always @(posedge system_clk) pc++;

    int n_tests = 0;
    int n_fail  = 0;
    int beat_pc [0:63];

    int            wq_col [$];
    int            wq_row [$];
    int            wq_pc  [$];
    logic [WD-1:0] wq_dat [$];
    int            dq_pc  [$];

    always @(negedge system_clk) begin
        if (window_valid) begin
            wq_col.push_back(int'(window_col));
            wq_row.push_back(int'(window_row));
            wq_pc.push_back(pc);
            wq_dat.push_back(window_data);
        end
        if (frame_done) dq_pc.push_back(pc);
    end

    task automatic check_val(input string tag, input logic [WD-1:0] got, input logic [WD-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_data(input int colv);
        logic [DW-1:0] v;
        v = '0;
        for (int c = 0; c < PE; c++) begin
            v[c*3*FW        +: FW] = FW'(colv + 10*c);
            v[c*3*FW + FW   +: FW] = FW'(colv + 10*c + 100);
            v[c*3*FW + 2*FW +: FW] = FW'(colv + 10*c + 200);
        end
        return v;
    endfunction

    function automatic logic [WD-1:0] exp_window(input int x);
        logic [WD-1:0] v;
        v = '0;
        for (int c = 0; c < PE; c++)
            for (int r = 0; r < 3; r++)
                for (int k = 0; k < 3; k++)
                    v[c*9*FW + (r*3+k)*FW +: FW] = FW'(x + k + 10*c + 100*(2-r));
        return v;
    endfunction

    task automatic clear_q();
        wq_col.delete(); wq_row.delete(); wq_pc.delete(); wq_dat.delete(); dq_pc.delete();
    endtask

    task automatic drive(input logic v, input int colv, input int idx);
        @(negedge system_clk);
        frame_start         = 1'b0;
        feature_cache_valid = v;
        feature_cache_data  = mk_data(colv);
        if (v) beat_pc[idx] = pc;
        @(posedge system_clk);
    endtask

    task automatic start_frame(input int cs, input int rs, input logic st,
                               input logic v, input int colv, input int idx);
        @(negedge system_clk);
        col_size            = 10'(cs);
        row_size            = 10'(rs);
        stride              = st;
        frame_start         = 1'b1;
        feature_cache_valid = v;
        feature_cache_data  = mk_data(colv);
        if (v) beat_pc[idx] = pc;
        @(posedge system_clk);
    endtask

    task automatic send_range(input int ecs, input int from, input int to, input bit gaps);
        for (int idx = from; idx <= to; idx++) begin
            if (gaps && idx > from) repeat ($urandom_range(0, 3)) drive(1'b0, 55, 0);
            drive(1'b1, idx % ecs, idx);
        end
    endtask

    task automatic flush();
        repeat (4) drive(1'b0, 55, 0);
    endtask

    task automatic check_win(input string name, input int k, input int x, input int y, input int beat);
        if (k < wq_col.size()) begin
            check_val($sformatf("%s w%0d col", name, k), wq_col[k], x);
            check_val($sformatf("%s w%0d row", name, k), wq_row[k], y);
            check_val($sformatf("%s w%0d latency", name, k), wq_pc[k], beat_pc[beat] + 1);
            check_val($sformatf("%s w%0d data", name, k), wq_dat[k], exp_window(x));
        end else begin
            check_val($sformatf("%s w%0d present", name, k), wq_col.size(), k + 1);
        end
    endtask

    task automatic check_done(input string name, input int beat);
        check_val({name, " done count"}, dq_pc.size(), 1);
        if (dq_pc.size() > 0) check_val({name, " done time"}, dq_pc[0], beat_pc[beat] + 1);
    endtask

    task automatic check_4x4(input string name);
        check_val({name, " win count"}, wq_col.size(), 4);
        check_win(name, 0, 0, 0, 10);
        check_win(name, 1, 1, 0, 11);
        check_win(name, 2, 0, 1, 14);
        check_win(name, 3, 1, 1, 15);
        check_done(name, 15);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WD-1:0] w0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge system_clk);
        @(negedge system_clk);
        check_val("reset window_valid", window_valid, 0);
        check_val("reset frame_done", frame_done, 0);
        check_val("reset window_col", window_col, 0);
        check_val("reset window_row", window_row, 0);
        check_val("reset window_data", window_data, 0);
        rst = 1'b0;

        // Valid beats in IDLE are ignored
        clear_q();
        send_range(4, 0, 5, 1'b0);
        flush();
        check_val("idle ignore wins", wq_col.size(), 0);
        check_val("idle ignore done", dq_pc.size(), 0);

        // 4x4 stride 1, back-to-back
        clear_q();
        start_frame(4, 4, 1'b0, 1'b0, 0, 0);
        send_range(4, 0, 15, 1'b0);
        flush();
        check_4x4("s1");
        if (wq_dat.size() > 0) begin
            w0 = wq_dat[0];
            check_val("s1 elem0", w0[7:0], 8'd200);
            check_val("s1 elem8", w0[71:64], 8'd2);
            check_val("s1 elem4", w0[39:32], 8'd101);
            check_val("s1 core1 elem0", w0[79:72], 8'd210);
        end else begin
            check_val("s1 first window present", wq_dat.size(), 1);
        end

        // 5x5 stride 2
        clear_q();
        start_frame(5, 5, 1'b1, 1'b0, 0, 0);
        send_range(5, 0, 24, 1'b0);
        flush();
        check_val("s2 win count", wq_col.size(), 4);
        check_win("s2", 0, 0, 0, 12);
        check_win("s2", 1, 2, 0, 14);
        check_win("s2", 2, 0, 2, 22);
        check_win("s2", 3, 2, 2, 24);
        check_done("s2", 24);

        // 4x4 stride 1 with random idle gaps
        clear_q();
        start_frame(4, 4, 1'b0, 1'b0, 0, 0);
        send_range(4, 0, 15, 1'b1);
        flush();
        check_4x4("gap");

        // Abort at beat 7 with frame_start + valid
        clear_q();
        start_frame(4, 4, 1'b0, 1'b0, 0, 0);
        send_range(4, 0, 6, 1'b0);
        start_frame(4, 4, 1'b0, 1'b1, 0, 0);
        send_range(4, 1, 15, 1'b0);
        flush();
        check_4x4("abort");

        // Reset at beat 9, then a 3x3 frame
        clear_q();
        start_frame(4, 4, 1'b0, 1'b0, 0, 0);
        send_range(4, 0, 8, 1'b0);
        @(negedge system_clk);
        rst = 1'b1;
        feature_cache_valid = 1'b1;
        repeat (2) @(posedge system_clk);
        @(negedge system_clk);
        check_val("rst mid window_valid", window_valid, 0);
        check_val("rst mid window_col", window_col, 0);
        check_val("rst mid window_row", window_row, 0);
        check_val("rst mid window_data", window_data, 0);
        rst = 1'b0;
        send_range(4, 9, 15, 1'b0);
        flush();
        check_val("rst discarded wins", wq_col.size(), 0);
        check_val("rst discarded done", dq_pc.size(), 0);
        clear_q();
        start_frame(3, 3, 1'b0, 1'b0, 0, 0);
        send_range(3, 0, 8, 1'b0);
        flush();
        check_val("3x3 win count", wq_col.size(), 1);
        check_win("3x3", 0, 0, 0, 8);
        check_done("3x3", 8);

        // Small frame: 2x2 produces no window but finishes
        clear_q();
        start_frame(2, 2, 1'b0, 1'b0, 0, 0);
        send_range(2, 0, 3, 1'b0);
        flush();
        check_val("2x2 win count", wq_col.size(), 0);
        check_done("2x2", 3);

        // Zero width treated as 1: 0x3 frame ends after 3 beats
        clear_q();
        start_frame(0, 3, 1'b0, 1'b0, 0, 0);
        send_range(1, 0, 2, 1'b0);
        send_range(1, 3, 4, 1'b0);
        flush();
        check_val("0x3 win count", wq_col.size(), 0);
        check_done("0x3", 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
